// File: rtl/gray_step_monitor.sv
// Tracks a Gray-coded position counter: decodes, classifies each step, counts revolutions, latches faults.
// Optional GRAY_STEP_MON_ERRCNT_EN adds a saturating illegal-transition counter (err_count).
module gray_step_monitor #(
    parameter int WIDTH = 4,
    parameter int REV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_fwd,
    output logic             step_rev,
    output logic             wrap,
    output logic [REV_W-1:0] rev_count,
    output logic             fault,
`ifdef GRAY_STEP_MON_ERRCNT_EN
    output logic [3:0]       err_count,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [REV_W-1:0] rev_count_q, rev_count_d;
    logic             fault_q, fault_d;
    logic             step_fwd_q, step_fwd_d;
    logic             step_rev_q, step_rev_d;
    logic             wrap_q, wrap_d;
    logic [3:0]       err_count_q, err_count_d;

    logic [WIDTH-1:0] bin_new;
    logic [WIDTH-1:0] delta;
    logic             illegal;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_new = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_new[i] = ^(gray_in >> i);
        end
    end

    // bin_q doubles as the previous sample: it always holds the last decoded code.
    assign delta   = bin_new - bin_q;
    assign illegal = (delta != '0) && (delta != BIN_ONE) && (delta != BIN_MAX);

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        rev_count_d = rev_count_q;
        fault_d     = fault_q;
        step_fwd_d  = 1'b0;
        step_rev_d  = 1'b0;
        wrap_d      = 1'b0;
        err_count_d = err_count_q;

        if (clear) begin
            state_d     = ST_INIT;
            rev_count_d = '0;
            fault_d     = 1'b0;
            err_count_d = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (en) begin
                        bin_d   = bin_new;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (en) begin
                        bin_d = bin_new;
                        if (delta == BIN_ONE) begin
                            step_fwd_d = 1'b1;
                            if (bin_q == BIN_MAX) begin
                                wrap_d      = 1'b1;
                                rev_count_d = rev_count_q + REV_W'(1);
                            end
                        end else if (delta == BIN_MAX) begin
                            step_rev_d = 1'b1;
                            if (bin_q == '0) begin
                                wrap_d      = 1'b1;
                                rev_count_d = rev_count_q - REV_W'(1);
                            end
                        end else if (illegal) begin
                            fault_d = 1'b1;
                            state_d = ST_FAULT;
                            if (err_count_q != 4'hF) err_count_d = err_count_q + 4'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    if (en) begin
                        bin_d = bin_new;
                        if (illegal && (err_count_q != 4'hF)) err_count_d = err_count_q + 4'd1;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            bin_q       <= '0;
            rev_count_q <= '0;
            fault_q     <= 1'b0;
            step_fwd_q  <= 1'b0;
            step_rev_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            rev_count_q <= rev_count_d;
            fault_q     <= fault_d;
            step_fwd_q  <= step_fwd_d;
            step_rev_q  <= step_rev_d;
            wrap_q      <= wrap_d;
        end
    end

`ifdef GRAY_STEP_MON_ERRCNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end
    assign err_count = err_count_q;
`else
    assign err_count_q = '0;
`endif

    assign bin_out   = bin_q;
    assign step_fwd  = step_fwd_q;
    assign step_rev  = step_rev_q;
    assign wrap      = wrap_q;
    assign rev_count = rev_count_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_gray_step_monitor.sv
// Directed, table-driven bench for gray_step_monitor plus hand-written reset and error-count sequences.
module tb_gray_step_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       clear;
    logic [3:0] gray_in;
    logic [3:0] bin_out;
    logic       step_fwd, step_rev, wrap, fault;
    logic [7:0] rev_count;
    logic [1:0] state;
`ifdef GRAY_STEP_MON_ERRCNT_EN
    logic [3:0] err_count;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       clr;
        logic       en;
        logic [3:0] gray;
        logic [3:0] bin;
        logic       fwd;
        logic       rev;
        logic       wrp;
        logic [7:0] rc;
        logic       flt;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    gray_step_monitor #(.WIDTH(4), .REV_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clear     (clear),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .step_fwd  (step_fwd),
        .step_rev  (step_rev),
        .wrap      (wrap),
        .rev_count (rev_count),
        .fault     (fault),
`ifdef GRAY_STEP_MON_ERRCNT_EN
        .err_count (err_count),
`endif
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic e, input logic [3:0] gr, input int b,
                       input logic f, input logic r, input logic w, input int rc,
                       input logic fl, input int st);
        vec_t v;
        v.clr = c; v.en = e; v.gray = gr; v.bin = 4'(b);
        v.fwd = f; v.rev = r; v.wrp = w; v.rc = 8'(rc); v.flt = fl; v.st = 2'(st);
        vecs.push_back(v);
    endtask

    task automatic check_all(input string tag, input int b, input int f, input int r,
                             input int w, input int rc, input int fl, input int st);
        check({tag, ".bin"},   int'(bin_out),   b);
        check({tag, ".fwd"},   int'(step_fwd),  f);
        check({tag, ".rev"},   int'(step_rev),  r);
        check({tag, ".wrap"},  int'(wrap),      w);
        check({tag, ".rc"},    int'(rev_count), rc);
        check({tag, ".fault"}, int'(fault),     fl);
        check({tag, ".state"}, int'(state),     st);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; clear = 1'b0; gray_in = 4'b0000;

        // Full revolution from 0000 after INIT
        add(0, 1, g(0), 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i < 16; i++) add(0, 1, g(i), i, 1, 0, 0, 0, 0, 1);
        add(0, 1, g(0), 0, 1, 0, 1, 1, 0, 1);
        // Reverse wrap, clear priority over en, then reverse wrap from rc=0
        add(0, 1, 4'b1000, 15, 0, 1, 1, 0, 0, 1);
        add(1, 1, 4'b0010, 15, 0, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 4'b1000, 15, 0, 1, 1, 255, 0, 1);
        add(0, 1, 4'b1000, 15, 0, 0, 0, 255, 0, 1);
        add(0, 0, 4'b0000, 15, 0, 0, 0, 255, 0, 1);
        add(0, 1, 4'b0000, 0, 1, 0, 1, 0, 0, 1);
        // Non-adjacent single-bit change faults; FAULT keeps tracking without pulses
        add(0, 1, 4'b0010, 3, 0, 0, 0, 0, 1, 2);
        add(0, 1, 4'b0110, 4, 0, 0, 0, 0, 1, 2);
        add(0, 1, 4'b0111, 5, 0, 0, 0, 0, 1, 2);
        add(0, 1, 4'b0000, 0, 0, 0, 0, 0, 1, 2);
        add(0, 0, 4'b0101, 0, 0, 0, 0, 0, 1, 2);
        add(1, 0, 4'b0101, 0, 0, 0, 0, 0, 0, 0);
        // Alternating enable: counter advances while en=0, sampled when en=1
        add(0, 1, g(0), 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            add(0, 0, g(i), i - 1, 0, 0, 0, 0, 0, 1);
            add(0, 1, g(i), i, 1, 0, 0, 0, 0, 1);
        end

        #12;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            clear   = vecs[k].clr;
            en      = vecs[k].en;
            gray_in = vecs[k].gray;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", k), int'(vecs[k].bin), int'(vecs[k].fwd),
                      int'(vecs[k].rev), int'(vecs[k].wrp), int'(vecs[k].rc),
                      int'(vecs[k].flt), int'(vecs[k].st));
        end

        // Async reset mid-count at bin 9, then re-seed from 0000 with no fault
        check("pre_rst.bin", int'(bin_out), 9);
        #2 reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        gray_in = 4'b0000; en = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all("reseed", 0, 0, 0, 0, 0, 0, 1);
        gray_in = 4'b0001;
        @(posedge clk); #1;
        check_all("reseed_step", 1, 1, 0, 0, 0, 0, 1);

`ifdef GRAY_STEP_MON_ERRCNT_EN
        check("err.initial", int'(err_count), 0);
        gray_in = 4'b0000; en = 1'b0; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 17; k++) begin
            gray_in = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            @(posedge clk); #1;
            if (k == 0) check("err.first", int'(err_count), 1);
            if (k == 14) check("err.at15", int'(err_count), 15);
        end
        check("err.sat", int'(err_count), 15);
        check("err.fault", int'(fault), 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("err.clear", int'(err_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_step_monitor.md
Name: gray_step_monitor

Overview:
- Sits directly downstream of the 4-bit Gray code counter.
- Samples the counter's Gray output each enabled cycle and decodes it to binary.
- Classifies each transition as hold, forward step, reverse step or illegal.
- Maintains a wrap-around (revolution) count and a sticky fault flag for the control/debug logic downstream.

Parameters:
- WIDTH, 4, Gray code width; must match the upstream counter.
- REV_W, 8, width of the revolution counter.

Ports:
- clk  input  1  rising-edge clock shared with the upstream counter.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- en  input  1  sample enable; gray_in is evaluated only when en=1.
- clear  input  1  synchronous clear of counters, fault and state; has priority over en.
- gray_in  input  WIDTH  Gray code from the upstream counter.
- bin_out  output  WIDTH  registered binary decode of the last sampled code.
- step_fwd  output  1  one-cycle pulse on a legal +1 step.
- step_rev  output  1  one-cycle pulse on a legal -1 step.
- wrap  output  1  one-cycle pulse on a legal step crossing max<->0.
- rev_count  output  REV_W  revolution count, modulo 2^REV_W.
- fault  output  1  sticky illegal-transition flag.
- state  output  2  FSM state: 0=INIT, 1=TRACK, 2=FAULT.

Behaviour:
- Reset (reset=0, async):
  - state=INIT.
  - bin_out, rev_count, step_fwd, step_rev, wrap and fault all 0.
  - Internal prev_gray/prev_bin = 0.
- Decode: bin[W-1]=g[W-1]; bin[i]=bin[i+1]^g[i].
- Comparison terms: delta = (bin(gray_in) - prev_bin) mod 2^WIDTH.
- Latency: all outputs are registered, so results appear 1 cycle after the sampling edge.
- step_fwd, step_rev and wrap are 0 in every cycle without a legal step.
- clear=1 (any state):
  - Next state INIT.
  - rev_count=0, fault=0, pulses 0; bin_out holds.
  - en is ignored that cycle.
- en=0: all registers hold, pulses 0.
- INIT, en=1:
  - Capture gray_in as prev and set bin_out = decode.
  - No pulses; go to TRACK.
- TRACK, en=1, classified on delta:
  - delta=0: hold, no pulses.
  - delta=1: step_fwd=1. If prev_bin=2^WIDTH-1, also wrap=1 and rev_count+1.
  - delta=2^WIDTH-1: step_rev=1. If prev_bin=0, also wrap=1 and rev_count-1.
  - Any other delta, including single-bit Gray changes that are non-adjacent (e.g. 0000->0010): fault=1, next state FAULT, no pulses, rev_count unchanged.
  - In every case, prev and bin_out update to the new sample.
- FAULT:
  - bin_out and prev keep tracking gray_in while en=1.
  - No step or wrap pulses; rev_count frozen; fault stays 1.
  - Exit only via clear or reset.
- rev_count wraps modulo 2^REV_W in both directions (0 - 1 -> 2^REV_W-1). No saturation.
- Reset asserted mid-operation: immediate return to reset values. After deassertion, the first enabled sample re-seeds from INIT, so there is no false fault when the upstream counter also resets to 0000.
- state encoding 3 is unreachable. If entered, next cycle goes to INIT.

Optional Feature:
- Macro: GRAY_STEP_MON_ERRCNT_EN.
- Defined:
  - Adds output port err_count, 4 bits, reset 0.
  - err_count increments on every illegal transition detected in TRACK or FAULT while en=1.
  - Saturates at 15; cleared by clear or reset.
- Undefined: no err_count port or logic; all other behaviour identical.

Test Plan:
- Reset low, release, en=1, upstream counter counts from 0000 for 16 clocks -> step_fwd=1 on each step after INIT, bin_out 0..15 then 0, wrap=1 exactly once on 1000->0000, rev_count=1, fault=0.
- From TRACK at gray 0000 (bin 0), drive 1000 (bin 15) -> step_rev=1, wrap=1, rev_count 0->2^REV_W-1 (255).
- From TRACK at 0000 drive 0010 -> fault=1, state=2, no pulses, bin_out=3. Then legal steps -> still no pulses. Then clear=1 -> state=0, fault=0, rev_count=0.
- en toggled 1/0 every cycle with the counter running every other cycle -> identical step/bin sequence as continuous run; no pulses in en=0 cycles.
- Assert reset mid-count at bin 9, release with upstream at 0000 -> all outputs 0 asynchronously, first sample enters TRACK with no fault.
- With GRAY_STEP_MON_ERRCNT_EN: inject 17 illegal transitions -> err_count saturates at 15; clear -> 0.
